// File: rtl/dev_pkg.sv
// rtl/dev_pkg.sv - shared register map, FSM states and constants for dev_intc
package dev_pkg;

    localparam logic [31:0] PEND_ADDR = 32'hF000_0100;
    localparam logic [31:0] MASK_ADDR = 32'hF000_0104;
    localparam logic [31:0] ID_ADDR   = 32'hF000_0108;
    localparam logic [31:0] EOI_ADDR  = 32'hF000_010C;

    // Value returned by the ID register when nothing is in service
    localparam logic [31:0] ID_NONE   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

endpackage

// File: rtl/dev_intc_prio.sv
// rtl/dev_intc_prio.sv - fixed-priority encoder, lowest set bit wins
module dev_intc_prio #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [W-1:0] idx
);

    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/dev_intc.sv
// rtl/dev_intc.sv - edge-latched, masked, fixed-priority interrupt controller
module dev_intc
    import dev_pkg::*;
#(
    parameter int               DBITS    = 32,
    parameter int               NIRQ     = 4,
    parameter logic [DBITS-1:0] PENDADDR = DBITS'(PEND_ADDR),
    parameter logic [DBITS-1:0] MASKADDR = DBITS'(MASK_ADDR),
    parameter logic [DBITS-1:0] IDADDR   = DBITS'(ID_ADDR),
    parameter logic [DBITS-1:0] EOIADDR  = DBITS'(EOI_ADDR),
    localparam int              IDW      = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] ABUS,
    input  logic             WE,
    input  logic [DBITS-1:0] DBUS_IN,
    output logic [DBITS-1:0] DBUS_OUT,
    input  logic [NIRQ-1:0]  IRQ,
    input  logic             INTA,
    output logic             INTR,
    output logic [IDW-1:0]   INTVEC
);

    intc_state_e     state_q, state_d;
    logic [NIRQ-1:0] irq_q, irq_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [IDW-1:0]  isr_id_q, isr_id_d;
    logic            intr_q, intr_d;

    logic [NIRQ-1:0] elig;
    logic            elig_any;
    logic [IDW-1:0]  elig_idx;
    logic [NIRQ-1:0] rise, w1c_clr, inta_clr;
    logic            wr_pend, wr_mask, wr_eoi;
    logic            unused_dbus_hi;

    assign elig    = pend_q & mask_q;
    assign rise    = IRQ & ~irq_q;
    assign wr_pend = WE && (ABUS == PENDADDR);
    assign wr_mask = WE && (ABUS == MASKADDR);
    assign wr_eoi  = WE && (ABUS == EOIADDR);
    assign w1c_clr = wr_pend ? DBUS_IN[NIRQ-1:0] : '0;

    assign unused_dbus_hi = ^DBUS_IN[DBITS-1:NIRQ];

    dev_intc_prio #(
        .N (NIRQ),
        .W (IDW)
    ) u_prio (
        .req (elig),
        .any (elig_any),
        .idx (elig_idx)
    );

    always_comb begin
        state_d  = state_q;
        isr_id_d = isr_id_q;
        inta_clr = '0;
        case (state_q)
            IDLE: begin
                if (elig_any) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!elig_any) begin
                    state_d = IDLE;
                end else if (INTA) begin
                    isr_id_d = elig_idx;
                    inta_clr = NIRQ'(1) << elig_idx;
                    state_d  = SERVICE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        irq_d  = IRQ;
        // A new rising edge outranks any clear landing on the same bit
        pend_d = (pend_q & ~(w1c_clr | inta_clr)) | rise;
        mask_d = wr_mask ? DBUS_IN[NIRQ-1:0] : mask_q;
        intr_d = (state_d == REQ);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            irq_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            isr_id_q <= '0;
            intr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            isr_id_q <= isr_id_d;
            intr_q   <= intr_d;
        end
    end

    assign INTR   = intr_q;
    assign INTVEC = elig_idx;

    // Reads are forced to zero while reset is held so ID does not show "none"
    always_comb begin
        DBUS_OUT = '0;
        if (RESET_N && !WE) begin
            if (ABUS == PENDADDR) begin
                DBUS_OUT = {{(DBITS-NIRQ){1'b0}}, pend_q};
            end else if (ABUS == MASKADDR) begin
                DBUS_OUT = {{(DBITS-NIRQ){1'b0}}, mask_q};
            end else if (ABUS == IDADDR) begin
                DBUS_OUT = (state_q == SERVICE) ? {{(DBITS-IDW){1'b0}}, isr_id_q}
                                                : DBITS'(ID_NONE);
            end
        end
    end

endmodule

// File: tb/tb_dev_intc.sv
// tb/tb_dev_intc.sv - self-checking bench for dev_intc with a behavioural model
module tb_dev_intc;

    localparam logic [31:0] A_PEND = 32'hF000_0100;
    localparam logic [31:0] A_MASK = 32'hF000_0104;
    localparam logic [31:0] A_ID   = 32'hF000_0108;
    localparam logic [31:0] A_EOI  = 32'hF000_010C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] abus = '0;
    logic        we = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [3:0]  irq = '0;
    logic        inta = 1'b0;
    logic        intr;
    logic [1:0]  intvec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dev_intc dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .ABUS     (abus),
        .WE       (we),
        .DBUS_IN  (din),
        .DBUS_OUT (dout),
        .IRQ      (irq),
        .INTA     (inta),
        .INTR     (intr),
        .INTVEC   (intvec)
    );

    // Model: mode 0 = waiting, 1 = requesting, 2 = in service
    logic [3:0] m_pend = '0;
    logic [3:0] m_mask = '0;
    logic [3:0] m_prev = '0;
    int         m_mode = 0;
    int         m_id   = 0;
    logic [3:0] mt_elig, mt_clr;
    int         mt_lo, mt_mode;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_rd();
        if (!rst_n || we) return 32'h0;
        if (abus == A_PEND) return {28'h0, m_pend};
        if (abus == A_MASK) return {28'h0, m_mask};
        if (abus == A_ID)   return (m_mode == 2) ? 32'(m_id) : 32'hFFFF_FFFF;
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0;
            m_mask = '0;
            m_prev = '0;
            m_mode = 0;
            m_id   = 0;
        end else begin
            mt_elig = m_pend & m_mask;
            mt_lo   = lowest(mt_elig);
            mt_clr  = (we && abus == A_PEND) ? din[3:0] : 4'h0;
            mt_mode = m_mode;
            if (m_mode == 0 && mt_elig != 0) begin
                mt_mode = 1;
            end else if (m_mode == 1 && mt_elig == 0) begin
                mt_mode = 0;
            end else if (m_mode == 1 && inta) begin
                mt_clr[mt_lo] = 1'b1;
                m_id          = mt_lo;
                mt_mode       = 2;
            end else if (m_mode == 2 && we && abus == A_EOI) begin
                mt_mode = 0;
            end
            m_pend = (m_pend & ~mt_clr) | (irq & ~m_prev);
            m_prev = irq;
            if (we && abus == A_MASK) m_mask = din[3:0];
            m_mode = mt_mode;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (intr !== (m_mode == 1)) begin
            errors++;
            $display("FAIL model_intr t=%0t got=%0b exp=%0b", $time, intr, (m_mode == 1));
        end
        checks++;
        if (dout !== exp_rd()) begin
            errors++;
            $display("FAIL model_dbus t=%0t addr=%h got=%h exp=%h", $time, abus, dout, exp_rd());
        end
        if (rst_n && m_mode == 1 && (m_pend & m_mask) != 0) begin
            checks++;
            if (int'(intvec) != lowest(m_pend & m_mask)) begin
                errors++;
                $display("FAIL model_intvec t=%0t got=%0d exp=%0d", $time, intvec,
                         lowest(m_pend & m_mask));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        abus = a;
        we   = 1'b0;
        #1;
        v = dout;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        abus = a;
        we   = 1'b1;
        din  = d;
        step(1);
        we   = 1'b0;
        abus = '0;
    endtask

    logic [31:0] v;

    initial begin
        abus = A_ID;
        #1;
        chk("rst_dbus_id", dout, 32'h0);
        chk("rst_intr", {31'h0, intr}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Single timer event through the full handshake
        wr(A_MASK, 32'h1);
        irq = 4'b0001;
        step(1);
        rd(A_PEND, v);
        chk("t1_pend_set", v, 32'h1);
        chk("t1_intr_low", {31'h0, intr}, 32'h0);
        step(1);
        chk("t1_intr_high", {31'h0, intr}, 32'h1);
        chk("t1_vec", {30'h0, intvec}, 32'h0);
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        chk("t1_intr_ack", {31'h0, intr}, 32'h0);
        rd(A_ID, v);
        chk("t1_id", v, 32'h0);
        rd(A_PEND, v);
        chk("t1_pend_clr", v, 32'h0);
        wr(A_EOI, 32'h0);
        step(2);
        chk("t1_no_reassert", {31'h0, intr}, 32'h0);
        irq = 4'b0000;

        // Two simultaneous sources, lowest index first
        wr(A_MASK, 32'hF);
        irq = 4'b1010;
        step(2);
        chk("t2_intr", {31'h0, intr}, 32'h1);
        chk("t2_vec1", {30'h0, intvec}, 32'h1);
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        rd(A_ID, v);
        chk("t2_id", v, 32'h1);
        wr(A_EOI, 32'h0);
        chk("t2_eoi_idle", {31'h0, intr}, 32'h0);
        step(1);
        chk("t2_reassert", {31'h0, intr}, 32'h1);
        chk("t2_vec3", {30'h0, intvec}, 32'h3);
        irq = 4'b0000;

        // Masking while requesting
        wr(A_MASK, 32'h0);
        chk("t3_still_req", {31'h0, intr}, 32'h1);
        step(1);
        chk("t3_masked", {31'h0, intr}, 32'h0);
        wr(A_MASK, 32'hF);
        step(1);
        chk("t3_unmasked", {31'h0, intr}, 32'h1);
        wr(A_PEND, 32'hF);
        step(1);
        chk("t3_w1c_idle", {31'h0, intr}, 32'h0);

        // Rising edge wins over W1C on the same bit
        wr(A_MASK, 32'h0);
        irq = 4'b0100;
        step(1);
        irq = 4'b0000;
        step(1);
        abus = A_PEND;
        we   = 1'b1;
        din  = 32'h4;
        irq  = 4'b0100;
        step(1);
        we = 1'b0;
        rd(A_PEND, v);
        chk("t4_edge_wins", v, 32'h4);
        wr(A_PEND, 32'h4);
        rd(A_PEND, v);
        chk("t4_w1c_only", v, 32'h0);
        rd(A_ID, v);
        chk("t4_id_none", v, 32'hFFFF_FFFF);
        irq = 4'b0000;
        step(1);

        // Level held high yields one event; EOI in idle does nothing
        irq = 4'b0001;
        step(100);
        rd(A_PEND, v);
        chk("t5_one_event", v, 32'h1);
        wr(A_PEND, 32'h1);
        rd(A_PEND, v);
        chk("t5_no_relatch", v, 32'h0);
        wr(A_EOI, 32'h0);
        chk("t5_eoi_idle", {31'h0, intr}, 32'h0);
        irq = 4'b0000;
        step(1);
        irq = 4'b0001;
        wr(A_MASK, 32'h1);
        step(1);
        chk("t5_req", {31'h0, intr}, 32'h1);
        inta = 1'b1;
        step(1);
        inta = 1'b0;
        irq  = 4'b0000;

        // Reset in the middle of service
        rst_n = 1'b0;
        #1;
        chk("t6_intr_async", {31'h0, intr}, 32'h0);
        step(1);
        rst_n = 1'b1;
        rd(A_PEND, v);
        chk("t6_pend", v, 32'h0);
        rd(A_MASK, v);
        chk("t6_mask", v, 32'h0);
        wr(A_MASK, 32'h1);
        step(3);
        chk("t6_no_event", {31'h0, intr}, 32'h0);
        irq = 4'b0001;
        step(2);
        chk("t6_fresh_edge", {31'h0, intr}, 32'h1);

        // Randomised traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: abus = A_PEND;
                1: abus = A_MASK;
                2: abus = A_ID;
                3: abus = A_EOI;
                4: abus = $urandom;
                default: abus = 32'h0;
            endcase
            din = $urandom;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            end
            inta = intr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #2;
                step(1);
                rst_n = 1'b1;
            end
            step(1);
        end
        we   = 1'b0;
        inta = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dev_intc.md
# dev_intc

Memory-mapped interrupt controller that sits directly downstream of the timer and the other I/O devices on the processor data bus. It turns device request levels (timer `ready`, keys, switches) into latched pending events, applies a software mask, and presents a single prioritised interrupt request to the CPU with an acknowledge/end-of-interrupt handshake. Software reads and writes its registers through the same ABUS/DBUS interface as the other devices.

## Interface
- `DBITS`, 32, bus data/address width
- `NIRQ`, 4, number of interrupt sources (1..DBITS-1)
- `PENDADDR`, 32'hF0000100, pending register address (read; write-1-to-clear)
- `MASKADDR`, 32'hF0000104, enable mask address (read/write)
- `IDADDR`, 32'hF0000108, in-service ID address (read only)
- `EOIADDR`, 32'hF000010C, end-of-interrupt address (write only, data ignored)

Ports:
- `CLK` in 1 — single clock; all state on rising edge
- `RESET_N` in 1 — asynchronous, active-low reset
- `ABUS` in DBITS — bus address
- `WE` in 1 — write enable for current bus cycle
- `DBUS_IN` in DBITS — write data
- `DBUS_OUT` out DBITS — read data; zero when no register is addressed or WE=1
- `IRQ` in NIRQ — device request levels; bit 0 is the timer
- `INTA` in 1 — CPU acknowledge, one-cycle pulse
- `INTR` out 1 — interrupt request to CPU
- `INTVEC` out ⌈log2 NIRQ⌉ — index of highest-priority eligible source, valid while INTR=1

## Operation
- Edge capture: `irq_q` registers IRQ each cycle; `rise = IRQ & ~irq_q` sets the matching PEND bit.
- Eligible set `elig = PEND & MASK`. Priority is fixed: lowest index wins.
- Register access:
  - PEND read returns {0, PEND}. A write clears bits where DBUS_IN=1.
  - MASK read/write covers the low NIRQ bits; upper bits read 0.
  - ID read returns the in-service index zero-extended while in SERVICE, and all-ones otherwise.
  - EOI write in SERVICE ends service. EOI in any other state is ignored.
- FSM states:
  - IDLE: go to REQ when elig≠0.
  - REQ: INTR=1.
    - elig becomes 0 (masked or W1C cleared) → return to IDLE.
    - INTA=1 with elig≠0 → capture INTVEC into `isr_id`, clear that PEND bit, go to SERVICE.
  - SERVICE: INTR=0; new events keep latching into PEND. EOI write → IDLE.
- INTA outside REQ is ignored. There is no nesting.
- Simultaneous events on one PEND bit:
  - a rising edge beats a W1C clear or an INTA clear, so the bit stays set;
  - a W1C clear and an INTA clear of the same bit in one cycle leave it clear.
- DBUS_OUT is combinational from ABUS/WE and register state, matching other devices.

## Timing
- Reset (async assert, sync-free deassert) clears:
  - PEND=0, MASK=0, irq_q=0, isr_id=0;
  - state=IDLE, INTR=0, INTVEC=0, DBUS_OUT=0 for any address.
- Latency:
  - IRQ seen high at edge k with irq_q low → PEND set after edge k.
  - If masked in, state=REQ and INTR=1 after edge k+1.
- INTA sampled at edge j in REQ → INTR=0 and ID valid after edge j.
- EOI write at edge j → IDLE after j. If elig≠0, INTR reasserts after j+1.
- Register writes take effect at the clock edge. Reads in the same cycle show the old value.
- Reset mid-service drops INTR immediately and discards all pending events.
- An IRQ held high across reset deassertion produces one event, because irq_q resets to 0.

## Structure
- Shared package `dev_pkg` holds:
  - the four address constants;
  - the state enum {IDLE, REQ, SERVICE};
  - the ID "none" constant (all-ones).
- One sub-module, `dev_intc_prio`: parameterised NIRQ-input priority encoder giving `any` and `idx` (lowest set bit). It is instantiated once on `elig`.

## Test plan
- Reset, MASK=4'b0001, IRQ[0] 0→1 at edge 10:
  - PEND=1 after edge 10; INTR=1, INTVEC=0 after edge 11.
  - INTA at edge 13 → INTR=0, ID reads 0, PEND reads 0.
- IRQ[3] and IRQ[1] rise together with MASK=4'hF:
  - INTVEC=1; after INTA and EOI, INTR reasserts with INTVEC=3.
- While in REQ, write MASK=0 → INTR drops after one edge. Write MASK=4'hF → INTR returns next edge.
- Same cycle, W1C of bit 2 plus a rising edge on IRQ[2] → PEND[2] stays 1. W1C alone → PEND[2]=0 and ID reads 32'hFFFFFFFF.
- IRQ[0] held high for 100 cycles → exactly one pending event. EOI written in IDLE → no state change.
- Assert RESET_N=0 mid-SERVICE:
  - INTR=0, PEND=0, MASK=0 immediately;
  - after release, a fresh edge with MASK set is required before INTR rises.
